pp_wr_fifo_reader: RTL and testbench
====================================

# pp_wr_fifo_reader

Consumer side of the periplex write-command FIFO: pops 48-bit command words from the write FIFO, decodes them into type, channel, register address and data fields, and presents each one to the peripheral fabric over a valid/ready handshake. It sits between the write FIFO read port and the per-channel peripheral dispatch logic. Reserved-type words are dropped and counted.

## Interface
- WIDTH, 48: FIFO word width; must be 48 (field map below).
- TIMEOUT, 256: handshake timeout in cycles; used only when the timeout feature is compiled in.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when low, no new pop is started; the word in flight completes.
- fifo_empty  in  1  write FIFO empty flag (combinational from FIFO count).
- fifo_rd_data  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO pop strobe, one cycle per word.
- cmd_valid  out  1  command presented.
- cmd_ready  in  1  fabric accepts the command.
- cmd_type  out  2  word[47:46]: 00 write, 01 read, 10 config.
- cmd_chan  out  6  word[45:40].
- cmd_addr  out  8  word[39:32].
- cmd_data  out  32  word[31:0].
- busy  out  1  high in any state other than IDLE.
- err_cnt  out  8  saturating count of dropped words.
- timeout  out  1  one-cycle pulse on handshake timeout.

## Operation
- Reset values: fifo_rd_en=0, cmd_valid=0, cmd_* fields=0, busy=0, err_cnt=0, timeout=0; state IDLE.
- The FSM has four states: IDLE, POP, WAIT, ISSUE.
- IDLE: if enable && !fifo_empty, go to POP; otherwise stay.
- POP: fifo_rd_en=1 for exactly this cycle; go to WAIT.
- WAIT: fifo_rd_data is valid; capture all 48 bits into the hold register at the end of the cycle.
  - If type is 11, do not issue. err_cnt increments (saturates at 255), then go to IDLE.
  - Otherwise go to ISSUE.
- ISSUE: cmd_valid=1 and cmd_* are driven from the hold register. Fields stay stable while cmd_valid && !cmd_ready.
  - On cmd_valid && cmd_ready: if enable && !fifo_empty, go to POP (back-to-back); otherwise go to IDLE.
- cmd_valid is never asserted outside ISSUE, and the fields are not changed while it is high.
- fifo_rd_en is asserted only in POP, so it is never asserted while fifo_empty is high.
- enable deasserted in POP, WAIT or ISSUE: the current word completes normally, then the FSM goes to IDLE.
- Reset asserted mid-operation: all state clears immediately. A word already popped but not handshaken is lost; this is by design.

## Timing
- fifo_empty low sampled in IDLE at edge N gives: POP in cycle N+1, WAIT in cycle N+2, cmd_valid high from cycle N+3.
- Minimum spacing between accepted commands with ready held high: 3 cycles (ISSUE→POP→WAIT→ISSUE).
- The hold register loads at the WAIT→ISSUE edge only.
- The err_cnt increment is visible the cycle after WAIT.
- busy is a registered decode of state, with no combinational path from inputs.

## Configuration
- Macro: PP_WR_READER_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in ISSUE and clears on entry to ISSUE.
  - If cmd_ready stays low for TIMEOUT consecutive ISSUE cycles, then: cmd_valid drops, the word is discarded, err_cnt increments, timeout pulses for one cycle, and the FSM goes to IDLE.
  - A handshake in the same cycle as expiry counts as accepted; no timeout is raised.
- Undefined: ISSUE waits indefinitely, the counter is not built, and timeout is tied 0.

## Test plan
- One write word 0x0_05_12_DEADBEEF (type 00, chan 05, addr 12) with cmd_ready high:
  - fifo_rd_en is high exactly one cycle.
  - cmd_valid rises 3 cycles after fifo_empty falls, with cmd_chan=05, cmd_addr=0x12, cmd_data=0xDEADBEEF.
  - busy returns low afterwards.
- Four words queued, cmd_ready always high:
  - Four handshakes, spaced 3 cycles apart, in FIFO order.
  - fifo_rd_en never high while fifo_empty is high.
- cmd_ready held low for 10 cycles, then high:
  - cmd_valid and all fields stay stable for all 10 cycles.
  - Exactly one handshake occurs.
- Type-11 word followed by a type-01 word:
  - No cmd_valid for the first word; err_cnt=1.
  - The second word issues with cmd_type=01.
  - 300 type-11 words leave err_cnt saturated at 255.
- Reset and enable:
  - rst_n pulsed low during WAIT: all outputs are 0 immediately, the FSM is in IDLE, and the FIFO has lost exactly one word.
  - enable low with a non-empty FIFO: no pop occurs.
- With PP_WR_READER_TIMEOUT_EN and TIMEOUT=16, cmd_ready held low:
  - cmd_valid drops after 16 ISSUE cycles.
  - timeout pulses once; err_cnt=1.
  - The next word is then popped.

Source files
------------

// File: rtl/pp_wr_fifo_reader_if.sv
// Write-FIFO read port plus decoded-command valid/ready handshake used by pp_wr_fifo_reader.
// master = the reader (pops the FIFO, drives commands); slave = FIFO and peripheral fabric side.
interface pp_wr_fifo_reader_if #(
    parameter int unsigned WIDTH = 48
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_rd_en;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_type;
    logic [5:0]       cmd_chan;
    logic [7:0]       cmd_addr;
    logic [31:0]      cmd_data;

    modport master (
        input  fifo_empty,
        input  fifo_rd_data,
        input  cmd_ready,
        output fifo_rd_en,
        output cmd_valid,
        output cmd_type,
        output cmd_chan,
        output cmd_addr,
        output cmd_data
    );

    modport slave (
        output fifo_empty,
        output fifo_rd_data,
        output cmd_ready,
        input  fifo_rd_en,
        input  cmd_valid,
        input  cmd_type,
        input  cmd_chan,
        input  cmd_addr,
        input  cmd_data
    );
endinterface

// File: rtl/pp_wr_fifo_reader.sv
// Pops 48-bit commands from the write FIFO, decodes and issues them over valid/ready; type-11
// words are dropped and counted. Optional handshake timeout: define PP_WR_READER_TIMEOUT_EN.
module pp_wr_fifo_reader #(
    parameter int unsigned WIDTH   = 48,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    pp_wr_fifo_reader_if.master bus,
    output logic                busy,
    output logic [7:0]          err_cnt,
    output logic                timeout
);
    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StWait,
        StIssue
    } state_e;

    localparam logic [1:0] TypeRsvd = 2'b11;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [7:0]       err_q, err_d;
    logic             busy_q;
    logic             timeout_q, timeout_d;
    logic             start_pop;
    logic             rsvd_word;
    logic             expire;
    logic [7:0]       err_inc;

    assign start_pop = enable && !bus.fifo_empty;
    assign rsvd_word = (bus.fifo_rd_data[47:46] == TypeRsvd);
    assign err_inc   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;

`ifdef PP_WR_READER_TIMEOUT_EN
    localparam int unsigned    CntW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counts ISSUE cycles already spent on the current word; zero on the first one.
    always_comb begin
        cnt_d = '0;
        if (state_q == StIssue && state_d == StIssue) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // A handshake on the expiry cycle wins, so expiry requires cmd_ready low.
    assign expire = (state_q == StIssue) && !bus.cmd_ready && (cnt_q == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign expire             = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        err_d     = err_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_pop) begin
                    state_d = StPop;
                end
            end
            StPop: begin
                state_d = StWait;
            end
            StWait: begin
                if (rsvd_word) begin
                    err_d   = err_inc;
                    state_d = StIdle;
                end else begin
                    hold_d  = bus.fifo_rd_data;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (bus.cmd_ready) begin
                    state_d = start_pop ? StPop : StIdle;
                end else if (expire) begin
                    err_d     = err_inc;
                    timeout_d = 1'b1;
                    state_d   = StIdle;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            err_q     <= err_d;
            busy_q    <= (state_d != StIdle);
            timeout_q <= timeout_d;
        end
    end

    assign bus.fifo_rd_en = (state_q == StPop);
    assign bus.cmd_valid  = (state_q == StIssue);
    assign bus.cmd_type   = hold_q[47:46];
    assign bus.cmd_chan   = hold_q[45:40];
    assign bus.cmd_addr   = hold_q[39:32];
    assign bus.cmd_data   = hold_q[31:0];
    assign busy           = busy_q;
    assign err_cnt        = err_q;
    assign timeout        = timeout_q;
endmodule

// File: tb/tb_pp_wr_fifo_reader.sv
// Bench for pp_wr_fifo_reader: a FIFO model feeds directed words; a per-cycle transaction model
// predicts pops, issues, drops and timeouts, and literal checks pin the model.
module tb_pp_wr_fifo_reader;
    localparam int unsigned TO = 16;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       ready = 1'b1;
    logic       busy;
    logic       timeout;
    logic [7:0] err_cnt;

    pp_wr_fifo_reader_if #(.WIDTH(48)) bus ();

    pp_wr_fifo_reader #(
        .WIDTH  (48),
        .TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable),
        .bus    (bus),
        .busy   (busy),
        .err_cnt(err_cnt),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the pop strobe.
    logic [47:0] mem [0:1023];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [47:0] rd_data_q = '0;

    assign bus.fifo_empty   = (wr_ptr == rd_ptr);
    assign bus.fifo_rd_data = rd_data_q;
    assign bus.cmd_ready    = ready;

    always @(posedge clk) begin
        if (bus.fifo_rd_en) begin
            rd_data_q <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_n = 0;
    int rd_n = 0;
    int to_n = 0;
    int          hs_cyc [0:15];
    logic [47:0] hs_w   [0:15];

    string       lit_name;
    logic [63:0] lit_act;
    logic [63:0] lit_exp;
    int          lit_seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: model state describes what the reader must be doing in the current cycle.
    initial begin
        int          lit_seen = 0;
        logic        prev_idle = 1'b1, prev_en = 1'b0, prev_empty = 1'b1;
        logic        prev_hs = 1'b0, prev_rd = 1'b0, prev_wait = 1'b0, prev_exp = 1'b0;
        logic        issuing = 1'b0;
        logic [47:0] pw = '0, iw = '0;
        int          icnt = 0;
        int          exp_err = 0;
        logic        exp_rd, wait_now, exp_to, exp_busy, hs, expn;
        forever begin
            @(negedge clk);
            if (lit_seq != lit_seen) begin
                chk(lit_name, lit_act, lit_exp);
                lit_seen = lit_seq;
            end
            if (!rst_n) begin
                chk("reset_outputs",
                    64'({bus.fifo_rd_en, bus.cmd_valid, busy, timeout, err_cnt, bus.cmd_type,
                         bus.cmd_chan, bus.cmd_addr, bus.cmd_data}), 64'd0);
                prev_idle = 1'b1; prev_en = 1'b0; prev_empty = 1'b1; prev_hs = 1'b0;
                prev_rd = 1'b0; prev_wait = 1'b0; prev_exp = 1'b0;
                issuing = 1'b0; icnt = 0; exp_err = 0;
            end else begin
                cyc++;
                exp_rd   = (prev_idle || prev_hs) && prev_en && !prev_empty;
                wait_now = prev_rd;
                exp_to   = prev_exp;
                if (prev_exp && exp_err < 255) exp_err++;
                if (prev_wait) begin
                    if (pw[47:46] == 2'b11) begin
                        if (exp_err < 255) exp_err++;
                    end else begin
                        issuing = 1'b1;
                        iw      = pw;
                        icnt    = 0;
                    end
                end else if (issuing && (prev_hs || prev_exp)) begin
                    issuing = 1'b0;
                end else if (issuing) begin
                    icnt++;
                end
                exp_busy = exp_rd || wait_now || issuing;

                chk("fifo_rd_en", 64'(bus.fifo_rd_en), 64'(exp_rd));
                chk("rd_while_empty", 64'(bus.fifo_rd_en && bus.fifo_empty), 64'd0);
                chk("cmd_valid", 64'(bus.cmd_valid), 64'(issuing));
                chk("busy", 64'(busy), 64'(exp_busy));
                chk("err_cnt", 64'(err_cnt), 64'(exp_err));
                chk("timeout", 64'(timeout), 64'(exp_to));
                if (issuing) begin
                    chk("cmd_fields",
                        64'({bus.cmd_type, bus.cmd_chan, bus.cmd_addr, bus.cmd_data}), 64'(iw));
                end

                if (exp_rd) pw = mem[rd_ptr];
                hs   = issuing && ready;
                expn = 1'b0;
`ifdef PP_WR_READER_TIMEOUT_EN
                expn = issuing && !ready && (icnt == int'(TO) - 1);
`endif
                if (hs) begin
                    if (hs_n < 16) begin
                        hs_cyc[hs_n] = cyc;
                        hs_w[hs_n]   = iw;
                    end
                    hs_n++;
                end
                if (bus.fifo_rd_en) rd_n++;
                if (timeout) to_n++;

                prev_idle  = !exp_busy;
                prev_rd    = exp_rd;
                prev_wait  = wait_now;
                prev_hs    = hs;
                prev_exp   = expn;
                prev_en    = enable;
                prev_empty = bus.fifo_empty;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [47:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        lit_name = name;
        lit_act  = act;
        lit_exp  = exp;
        lit_seq++;
        tick(1);
    endtask

    initial begin
        int t_push, rp0, rd0, to0;
        tick(3);
        rst_n = 1'b1;
        tick(2);
        enable = 1'b1;
        tick(2);

        // Single write word
        rd0    = rd_n;
        t_push = cyc + 1;
        push(48'h0512_DEADBEEF);
        tick(8);
        lit("single_hs_count", 64'(hs_n), 64'd1);
        lit("single_word", 64'(hs_w[0]), 64'h0512_DEADBEEF);
        lit("single_latency", 64'(hs_cyc[0] - t_push), 64'd3);
        lit("single_rd_pulses", 64'(rd_n - rd0), 64'd1);
        lit("single_busy_low", 64'(busy), 64'd0);

        // Four queued words, back-to-back
        push(48'h0A01_11111111);
        push(48'h4B02_22222222);
        push(48'h8C03_33333333);
        push(48'h0D04_44444444);
        tick(16);
        lit("burst_hs_count", 64'(hs_n), 64'd5);
        lit("burst_gap_a", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
        lit("burst_gap_b", 64'(hs_cyc[3] - hs_cyc[2]), 64'd3);
        lit("burst_gap_c", 64'(hs_cyc[4] - hs_cyc[3]), 64'd3);
        lit("burst_last_word", 64'(hs_w[4]), 64'h0D04_44444444);

        // Back-pressure for 10 ISSUE cycles
        ready  = 1'b0;
        t_push = cyc + 1;
        push(48'h1520_5555AAAA);
        tick(13);
        ready = 1'b1;
        tick(4);
        lit("stall_hs_count", 64'(hs_n), 64'd6);
        lit("stall_hs_cycle", 64'(hs_cyc[5] - t_push), 64'd13);
        lit("stall_word", 64'(hs_w[5]), 64'h1520_5555AAAA);

        // Reserved word then a read word
        push(48'hC102_0BAD0BAD);
        push(48'h4744_12345678);
        tick(10);
        lit("drop_err_cnt", 64'(err_cnt), 64'd1);
        lit("drop_hs_count", 64'(hs_n), 64'd7);
        lit("drop_next_type", 64'(hs_w[6][47:46]), 64'd1);

        // Saturation
        for (int i = 0; i < 300; i++) push({2'b11, 46'(i)});
        tick(920);
        lit("err_saturated", 64'(err_cnt), 64'd255);
        lit("sat_no_issue", 64'(hs_n), 64'd7);

        // Reset during WAIT loses the popped word
        rp0 = rd_ptr;
        push(48'h0201_CAFEF00D);
        push(48'h0302_0000BEEF);
        tick(2);
        rst_n = 1'b0;
        #1;
        lit("rst_err_clear", 64'(err_cnt), 64'd0);
        lit("rst_busy_clear", 64'(busy), 64'd0);
        rst_n = 1'b1;
        tick(10);
        lit("rst_hs_count", 64'(hs_n), 64'd8);
        lit("rst_next_word", 64'(hs_w[7]), 64'h0302_0000BEEF);
        lit("rst_words_used", 64'(rd_ptr - rp0), 64'd2);

        // Enable low holds off pops
        enable = 1'b0;
        rp0    = rd_ptr;
        push(48'h0455_00C0FFEE);
        tick(10);
        lit("dis_no_pop", 64'(rd_ptr - rp0), 64'd0);
        lit("dis_busy", 64'(busy), 64'd0);
        enable = 1'b1;
        tick(6);
        lit("en_hs_count", 64'(hs_n), 64'd9);
        lit("en_word", 64'(hs_w[8]), 64'h0455_00C0FFEE);

`ifdef PP_WR_READER_TIMEOUT_EN
        // Handshake timeout, then the next word is popped
        to0    = to_n;
        ready  = 1'b0;
        t_push = cyc + 1;
        push(48'h0566_11110000);
        push(48'h0677_22220000);
        tick(19);
        ready = 1'b1;
        tick(8);
        lit("to_pulses", 64'(to_n - to0), 64'd1);
        lit("to_err_cnt", 64'(err_cnt), 64'd1);
        lit("to_hs_count", 64'(hs_n), 64'd10);
        lit("to_next_word", 64'(hs_w[9]), 64'h0677_22220000);
        lit("to_next_cycle", 64'(hs_cyc[9] - t_push), 64'd22);
`else
        to0 = to_n;
        lit("no_timeout", 64'(to_n - to0 + int'(timeout)), 64'd0);
`endif

        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
